// File: rtl/control_word_decoder.sv
// Control word decoder for the 8-bit CPU: turns the sequencer stage and the
// instruction opcode into the registered 15-bit datapath control word. It also
// holds the halt latch, the illegal-opcode flag and the retired-instruction count.
module control_word_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  stage_i,
  input  logic [3:0]  opcode_i,
  output logic [14:0] ctrl_o,
  output logic        halted_o,
  output logic        illegal_o,
  output logic [7:0]  retired_o
);

  // Stage codes from the sequencer
  localparam logic [2:0] StageT0 = 3'd0;
  localparam logic [2:0] StageT1 = 3'd1;
  localparam logic [2:0] StageT2 = 3'd2;
  localparam logic [2:0] StageT3 = 3'd3;
  localparam logic [2:0] StageT4 = 3'd4;
  localparam logic [2:0] StageT5 = 3'd5;

  // Opcodes
  localparam logic [3:0] OpHlt = 4'h0;
  localparam logic [3:0] OpNop = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpLda = 4'h4;
  localparam logic [3:0] OpOut = 4'h5;
  localparam logic [3:0] OpSta = 4'h6;
  localparam logic [3:0] OpJmp = 4'h7;

  // Control words (active-low signals idle high in CwNop)
  localparam logic [14:0] CwNop     = 15'h0FE3;
  localparam logic [14:0] CwFetch0  = 15'h27E3; // E_P, /L_MA
  localparam logic [14:0] CwFetch1  = 15'h4FE3; // C_P
  localparam logic [14:0] CwFetch2  = 15'h0D63; // /CE, /L_I
  localparam logic [14:0] CwAddrIr  = 15'h07A3; // /E_I, /L_MA
  localparam logic [14:0] CwRamToA  = 15'h0DC3; // /CE, /L_A
  localparam logic [14:0] CwRamToB  = 15'h0DE1; // /CE, /L_B
  localparam logic [14:0] CwSumToA  = 15'h0FC7; // E_U, /L_A
  localparam logic [14:0] CwDiffToA = 15'h0FCF; // S_U, E_U, /L_A
  localparam logic [14:0] CwAToOut  = 15'h0FF2; // E_A, /L_O
  localparam logic [14:0] CwAToRam  = 15'h0EF3; // E_A, /L_R
  localparam logic [14:0] CwIrToPc  = 15'h1FA3; // /E_I, L_P

  logic [14:0] ctrl_d, ctrl_q;
  logic [3:0]  opcode_d, opcode_q;
  logic        halted_d, halted_q;
  logic        illegal_d, illegal_q;
  logic [7:0]  retired_d, retired_q;

  logic [3:0]  exec_op;
  logic        is_t3;
  logic        hlt_now;

  // Execute-stage word for one opcode; st is T3/T4/T5
  function automatic logic [14:0] exec_word(input logic [3:0] op, input logic [2:0] st);
    logic [14:0] w;
    w = CwNop;
    case (op)
      OpLda: begin
        if (st == StageT3)      w = CwAddrIr;
        else if (st == StageT4) w = CwRamToA;
      end
      OpAdd: begin
        if (st == StageT3)      w = CwAddrIr;
        else if (st == StageT4) w = CwRamToB;
        else                    w = CwSumToA;
      end
      OpSub: begin
        if (st == StageT3)      w = CwAddrIr;
        else if (st == StageT4) w = CwRamToB;
        else                    w = CwDiffToA;
      end
      OpOut: if (st == StageT3) w = CwAToOut;
      OpSta: begin
        if (st == StageT3)      w = CwAddrIr;
        else if (st == StageT4) w = CwAToRam;
      end
      OpJmp: if (st == StageT3) w = CwIrToPc;
      OpHlt, OpNop: w = CwNop;
      default: w = CwNop; // undefined opcodes execute as NOP
    endcase
    return w;
  endfunction

  assign is_t3   = (stage_i == StageT3);
  // T3 decodes the live opcode; T4/T5 use the one captured at T3
  assign exec_op = is_t3 ? opcode_i : opcode_q;
  assign hlt_now = is_t3 && (opcode_i == OpHlt);

  // Next-state: control word, opcode capture, latches and retire counter
  always_comb begin
    ctrl_d    = CwNop;
    opcode_d  = opcode_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retired_d = retired_q;

    case (stage_i)
      StageT0: ctrl_d = CwFetch0;
      StageT1: ctrl_d = CwFetch1;
      StageT2: ctrl_d = CwFetch2;
      StageT3, StageT4, StageT5: ctrl_d = exec_word(exec_op, stage_i);
      default: ctrl_d = CwNop; // IDLE and invalid stages
    endcase

    if (halted_q || hlt_now) begin
      ctrl_d = CwNop;
    end

    if (is_t3) begin
      opcode_d = opcode_i;
      if (opcode_i == OpHlt) halted_d = 1'b1;
      if (opcode_i[3])       illegal_d = 1'b1;
    end

    if ((stage_i == StageT5) && !halted_q) begin
      retired_d = retired_q + 8'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= CwNop;
      opcode_q  <= OpNop;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= 8'd0;
    end else begin
      ctrl_q    <= ctrl_d;
      opcode_q  <= opcode_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign halted_o  = halted_q;
  assign illegal_o = illegal_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_control_word_decoder.sv
// Self-checking bench for control_word_decoder: directed scenarios followed by
// random stage/opcode traffic, all compared against a table-driven model.
module tb_control_word_decoder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  stage_i;
  logic [3:0]  opcode_i;
  logic [14:0] ctrl_o;
  logic        halted_o;
  logic        illegal_o;
  logic [7:0]  retired_o;

  int unsigned n_checks;
  int unsigned n_fail;

  // Reference model state
  logic [14:0] fetch_tbl [0:2];
  logic [14:0] exec_tbl  [0:15][0:2];
  logic [14:0] m_ctrl;
  logic [3:0]  m_op;
  bit          m_halted;
  bit          m_illegal;
  int          m_retired;

  control_word_decoder u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stage_i   (stage_i),
    .opcode_i  (opcode_i),
    .ctrl_o    (ctrl_o),
    .halted_o  (halted_o),
    .illegal_o (illegal_o),
    .retired_o (retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model one clock edge from the pre-edge state and the applied inputs
  task automatic model_edge(input bit rst, input int st, input int op);
    if (!rst) begin
      m_ctrl = 15'h0FE3; m_op = 4'h1; m_halted = 0; m_illegal = 0; m_retired = 0;
      return;
    end
    if (m_halted)       m_ctrl = 15'h0FE3;
    else if (st <= 2)   m_ctrl = fetch_tbl[st];
    else if (st == 3)   m_ctrl = exec_tbl[op][0];
    else if (st <= 5)   m_ctrl = exec_tbl[m_op][st-3];
    else                m_ctrl = 15'h0FE3;
    if (st == 3) begin
      m_op = op[3:0];
      if (op == 0) m_halted = 1;
      if (op >= 8) m_illegal = 1;
    end
    if (st == 5 && !m_halted) m_retired = (m_retired + 1) % 256;
  endtask

  // Apply inputs, clock once, then compare every output against the model
  task automatic step(input bit rst, input int st, input int op, input string tag);
    rst_n    = rst;
    stage_i  = st[2:0];
    opcode_i = op[3:0];
    @(posedge clk);
    model_edge(rst, st, op);
    #1;
    check({tag, ".ctrl"},    32'(ctrl_o),    32'(m_ctrl));
    check({tag, ".halted"},  32'(halted_o),  32'(m_halted));
    check({tag, ".illegal"}, 32'(illegal_o), 32'(m_illegal));
    check({tag, ".retired"}, 32'(retired_o), 32'(m_retired));
  endtask

  task automatic run_instr(input int op, input string tag);
    for (int s = 0; s < 6; s++) step(1, s, op, tag);
  endtask

  initial begin
    int cur;
    int st;
    int op;
    n_checks = 0;
    n_fail   = 0;

    fetch_tbl[0] = 15'h27E3;
    fetch_tbl[1] = 15'h4FE3;
    fetch_tbl[2] = 15'h0D63;
    for (int o = 0; o < 16; o++)
      for (int k = 0; k < 3; k++) exec_tbl[o][k] = 15'h0FE3;
    exec_tbl[4] = '{15'h07A3, 15'h0DC3, 15'h0FE3}; // LDA
    exec_tbl[2] = '{15'h07A3, 15'h0DE1, 15'h0FC7}; // ADD
    exec_tbl[3] = '{15'h07A3, 15'h0DE1, 15'h0FCF}; // SUB
    exec_tbl[5] = '{15'h0FF2, 15'h0FE3, 15'h0FE3}; // OUT
    exec_tbl[6] = '{15'h07A3, 15'h0EF3, 15'h0FE3}; // STA
    exec_tbl[7] = '{15'h1FA3, 15'h0FE3, 15'h0FE3}; // JMP

    rst_n = 1'b0; stage_i = 3'd6; opcode_i = 4'h1;
    m_ctrl = 15'h0FE3; m_op = 4'h1; m_halted = 0; m_illegal = 0; m_retired = 0;

    // Reset, idle and fetch
    step(0, 6, 1, "reset");
    check("reset_word", 32'(ctrl_o), 32'h0FE3);
    step(1, 6, 1, "idle");
    step(1, 0, 1, "t0");
    check("t0_word", 32'(ctrl_o), 32'h27E3);
    step(1, 1, 1, "t1");
    step(1, 2, 1, "t2");
    check("t2_word", 32'(ctrl_o), 32'h0D63);

    // ADD with opcode changed after T3
    step(1, 3, 2, "add_t3");
    step(1, 4, 4, "add_t4");
    check("add_t4_word", 32'(ctrl_o), 32'h0DE1);
    step(1, 5, 4, "add_t5");
    check("add_t5_word", 32'(ctrl_o), 32'h0FC7);
    check("add_retired", 32'(retired_o), 32'd1);

    run_instr(3, "sub");
    run_instr(6, "sta");
    run_instr(7, "jmp");
    run_instr(5, "out");
    run_instr(4, "lda");

    // Illegal opcode: sticky flag, NOP execution, still retires
    run_instr(4'hA, "illegal");
    check("illegal_sticky", 32'(illegal_o), 32'd1);
    run_instr(1, "post_illegal");

    // HLT freezes the word and counter
    step(1, 0, 0, "hlt_t0");
    step(1, 1, 0, "hlt_t1");
    step(1, 2, 0, "hlt_t2");
    step(1, 3, 0, "hlt_t3");
    check("hlt_flag", 32'(halted_o), 32'd1);
    run_instr(2, "halted");
    check("halted_fetch", 32'(ctrl_o), 32'h0FE3);
    step(0, 0, 1, "hlt_reset");
    check("hlt_cleared", 32'(halted_o), 32'd0);

    // 256 NOPs wrap the retire counter
    for (int i = 0; i < 256; i++) run_instr(1, "wrap");
    check("wrap_zero", 32'(retired_o), 32'd0);

    // Reset during T4 of LDA drops the captured opcode
    step(1, 0, 4, "lda_t0");
    step(1, 1, 4, "lda_t1");
    step(1, 2, 4, "lda_t2");
    step(1, 3, 4, "lda_t3");
    step(0, 4, 4, "lda_rst");
    step(1, 4, 4, "after_rst_t4");
    check("opq_reset_nop", 32'(ctrl_o), 32'h0FE3);
    step(1, 5, 2, "after_rst_t5");

    // Random traffic: mostly in-order stages, occasional jumps and resets
    cur = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        step(0, $urandom_range(0, 7), $urandom_range(0, 15), "rand_rst");
        cur = 0;
        continue;
      end
      if ($urandom_range(0, 99) < 80) st = cur;
      else st = $urandom_range(0, 7);
      op = $urandom_range(0, 15);
      if (op == 0 && $urandom_range(0, 3) != 0) op = 1; // keep halts rarer
      step(1, st, op, "rand");
      cur = (st >= 5) ? 0 : st + 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_word_decoder.md
# control_word_decoder

Downstream companion of the stage sequencer in the 8-bit CPU. It consumes the 3-bit micro-op stage (T0–T5, IDLE) and the 4-bit instruction opcode, and produces the registered 15-bit control word that drives the PC, MAR, RAM, IR, A/B registers, adder and output register. It also latches opcodes for the execute stages, implements the HLT halt latch, flags illegal opcodes and counts retired instructions.

## Interface
- No parameters; widths are fixed by the CPU datapath.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `stage_i` input 3: stage from sequencer; 0–5 = T0–T5, 6 = IDLE, 7 = invalid.
- `opcode_i` input 4: IR upper nibble. HLT=0, NOP=1, ADD=2, SUB=3, LDA=4, OUT=5, STA=6, JMP=7; 8–F undefined.
- `ctrl_o` output 15: control word. Bits 14 C_P, 13 E_P, 12 L_P, 11 /L_MA, 10 /L_MD, 9 /CE, 8 /L_R, 7 /L_I, 6 /E_I, 5 /L_A, 4 E_A, 3 S_U, 2 E_U, 1 /L_B, 0 /L_O. `/` denotes active-low.
- `halted_o` output 1: sticky; set by HLT.
- `illegal_o` output 1: sticky; set by an undefined opcode.
- `retired_o` output 8: retired-instruction count.

## Operation
- NOP word (all signals inactive) = 0x0FE3. This is also the reset value of `ctrl_o`.
- Fetch, independent of opcode:
  - T0 → 0x27E3 (E_P, /L_MA).
  - T1 → 0x4FE3 (C_P).
  - T2 → 0x0D63 (/CE, /L_I).
- Execute (T3 decodes live `opcode_i`; T4/T5 decode `opcode_q`):
  - LDA: T3 0x07A3 (/E_I, /L_MA); T4 0x0DC3 (/CE, /L_A); T5 0x0FE3.
  - ADD: T3 0x07A3; T4 0x0DE1 (/CE, /L_B); T5 0x0FC7 (E_U, /L_A).
  - SUB: as ADD, except T5 = 0x0FCF (adds S_U).
  - OUT: T3 0x0FF2 (E_A, /L_O); T4 and T5 0x0FE3.
  - STA: T3 0x07A3; T4 0x0EF3 (E_A, /L_R); T5 0x0FE3.
  - JMP: T3 0x1FA3 (/E_I, L_P); T4 and T5 0x0FE3.
  - HLT, NOP, undefined: 0x0FE3 in T3–T5.
- `opcode_q` captures `opcode_i` on the T3 edge and holds through T4/T5. Its reset value is 1 (NOP).
- Halt latch: set on the edge where `stage_i`=3 and `opcode_i`=0. Once set, `ctrl_o` is forced to 0x0FE3 every cycle, regardless of stage, until reset.
- Illegal latch: set on the edge where `stage_i`=3 and `opcode_i`≥8. Execution continues as NOP.
- `retired_o`: +1 on each edge where `stage_i`=5 and not halted. 8-bit, wraps 255→0.
- IDLE (6) and invalid (7) stages → 0x0FE3; no latch or counter changes.

## Timing
- `ctrl_o` is registered, with 1-cycle latency: the word for the stage sampled at edge N appears after edge N and holds until edge N+1.
- `halted_o` and `illegal_o` assert after the same edge that samples the T3 stage. On that edge `ctrl_o` already shows 0x0FE3 (HLT).
- Simultaneous events:
  - Halt set and T5 cannot coincide.
  - A T5 sampled while halted does not increment `retired_o`.
- Reset mid-instruction, on the reset edge:
  - `ctrl_o`=0x0FE3, `halted_o`=0, `illegal_o`=0, `retired_o`=0, `opcode_q`=1.
  - Any partially decoded instruction is dropped.
- Reset has priority over all other updates.
- `opcode_i` changes outside T3 have no effect on T4/T5 words.

## Test plan
- Reset, then stage sequence 6,0,1,2 → `ctrl_o` after each edge: 0x0FE3, 0x27E3, 0x4FE3, 0x0D63.
- ADD: stage 3,4,5 with `opcode_i`=2 at T3, then changed to 4 at T4 → 0x07A3, 0x0DE1, 0x0FC7; `retired_o`=1.
- SUB, STA, JMP, OUT each through T3–T5 → SUB T5 0x0FCF; STA T4 0x0EF3; JMP T3 0x1FA3; OUT T3 0x0FF2.
- HLT at T3 → `halted_o`=1 next cycle; subsequent T0/T1 stages give 0x0FE3; `retired_o` frozen; `rst_n` low for 1 edge clears everything.
- Opcode 0xA at T3 → `illegal_o`=1 and sticky; T4/T5 give 0x0FE3; `retired_o` still increments.
- 256 NOP instructions → `retired_o` wraps to 0. Reset asserted at T4 of LDA → `ctrl_o`=0x0FE3 on that edge and `opcode_q`=1.
